// File: rtl/key_packet_assembler_pkg.sv
// key_packet_assembler_pkg: FSM states, packet width and field slices shared with the scheduler stage
package key_packet_assembler_pkg;
    localparam int PKT_BITS = 4;
    localparam int DEST_MSB = 3;
    localparam int DEST_LSB = 2;
    localparam int PAY_MSB  = 1;
    localparam int PAY_LSB  = 0;
    typedef logic [1:0] state_t;
    localparam state_t IDLE    = 2'd0;
    localparam state_t COLLECT = 2'd1;
    localparam state_t SEND    = 2'd2;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-FF synchroniser, hold-time debouncer and rising-edge press pulse
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    logic [1:0] sync;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], raw};
            press <= 1'b0;
            if (sync[1] == level)
                cnt <= '0;
            else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync[1];
                press <= sync[1];
                cnt   <= '0;
            end else
                cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: rtl/key_packet_assembler.sv
// key_packet_assembler: debounced button entry of a 4-bit packet delivered over valid/ready
module key_packet_assembler
    import key_packet_assembler_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int TIMEOUT_CYCLES  = 500000000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                key1,
    input  logic                key2,
    output logic [PKT_BITS-1:0] pkt_data,
    output logic                pkt_valid,
    input  logic                pkt_ready,
    output logic [2:0]          bit_cnt,
    output logic                busy,
    output logic                abort
);
    localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    logic start_p, key1_p, key2_p, bit_p;
    logic [2:0] levels_unused;
    logic [PKT_BITS-1:0] shreg, next_sh;
    logic [TW-1:0] tcnt;
    state_t state;
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
        .clk(clk), .rst_n(rst_n), .raw(start), .level(levels_unused[0]), .press(start_p));
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key1 (
        .clk(clk), .rst_n(rst_n), .raw(key1), .level(levels_unused[1]), .press(key1_p));
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key2 (
        .clk(clk), .rst_n(rst_n), .raw(key2), .level(levels_unused[2]), .press(key2_p));
    // a simultaneous key1+key2 press is ambiguous, so only a lone key counts
    assign bit_p   = key1_p ^ key2_p;
    assign next_sh = {shreg[PKT_BITS-2:0], key1_p};
    assign busy    = state != IDLE;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            shreg     <= '0;
            tcnt      <= '0;
            bit_cnt   <= '0;
            pkt_data  <= '0;
            pkt_valid <= 1'b0;
            abort     <= 1'b0;
        end else begin
            abort <= 1'b0;
            case (state)
                IDLE: if (start_p) begin
                    state   <= COLLECT;
                    shreg   <= '0;
                    tcnt    <= '0;
                    bit_cnt <= '0;
                end
                COLLECT: if (start_p) begin
                    shreg   <= '0;
                    tcnt    <= '0;
                    bit_cnt <= '0;
                end else if (bit_p) begin
                    shreg   <= next_sh;
                    tcnt    <= '0;
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'(PKT_BITS - 1)) begin
                        pkt_data  <= next_sh;
                        pkt_valid <= 1'b1;
                        state     <= SEND;
                    end
                end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    abort   <= 1'b1;
                    bit_cnt <= '0;
                    state   <= IDLE;
                end else
                    tcnt <= tcnt + TW'(1);
                SEND: if (pkt_ready) begin
                    pkt_valid <= 1'b0;
                    bit_cnt   <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_key_packet_assembler.sv
// tb_key_packet_assembler: directed scenarios plus random buttons checked against a behavioural model
module tb_key_packet_assembler;
    localparam int D = 4;
    localparam int T = 50;
    logic clk = 0, rst_n = 0, start = 0, key1 = 0, key2 = 0, pkt_ready = 0;
    logic [3:0] pkt_data;
    logic pkt_valid, busy, abort;
    logic [2:0] bit_cnt;
    int total = 0, bad = 0;
    int n_abort = 0, n_valid = 0, nx, na, nv, lat;
    logic [3:0] xfers[$];
    bit hist [3][D+2];
    bit lev [3];
    bit prs [3];
    int mode, idle_cyc;
    bit bits[$];
    logic [3:0] e_data;
    bit e_valid, e_abort;
    always #5 clk = ~clk;
    key_packet_assembler #(.DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key1(key1), .key2(key2),
        .pkt_data(pkt_data), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
        .bit_cnt(bit_cnt), .busy(busy), .abort(abort));
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask
    // model: a button level flips once the last D synchronised samples all disagree with it
    always @(posedge clk) begin
        bit raw [3];
        bit nprs [3];
        bit flip, ps, k1, k2;
        raw[0] = start;
        raw[1] = key1;
        raw[2] = key2;
        if (!rst_n) begin
            for (int b = 0; b < 3; b++) begin
                lev[b] = 0;
                prs[b] = 0;
                for (int k = 0; k < D + 2; k++) hist[b][k] = 0;
            end
            mode = 0;
            bits.delete();
            idle_cyc = 0;
            e_data = 0;
            e_valid = 0;
            e_abort = 0;
        end else begin
            ps = prs[0];
            k1 = prs[1];
            k2 = prs[2];
            for (int b = 0; b < 3; b++) begin
                flip = 1;
                for (int k = 0; k < D; k++) if (hist[b][k+1] == lev[b]) flip = 0;
                nprs[b] = flip && !lev[b];
                if (flip) lev[b] = !lev[b];
                for (int k = D + 1; k > 0; k--) hist[b][k] = hist[b][k-1];
                hist[b][0] = raw[b];
            end
            e_abort = 0;
            case (mode)
                0: if (ps) begin
                    mode = 1;
                    bits.delete();
                    idle_cyc = 0;
                end
                1: if (ps) begin
                    bits.delete();
                    idle_cyc = 0;
                end else if (k1 != k2) begin
                    bits.push_back(k1);
                    idle_cyc = 0;
                    if (bits.size() == 4) begin
                        e_data = {bits[0], bits[1], bits[2], bits[3]};
                        e_valid = 1;
                        mode = 2;
                    end
                end else begin
                    idle_cyc++;
                    if (idle_cyc == T) begin
                        e_abort = 1;
                        mode = 0;
                        bits.delete();
                    end
                end
                default: if (pkt_ready) begin
                    e_valid = 0;
                    mode = 0;
                    bits.delete();
                end
            endcase
            prs = nprs;
        end
    end
    always @(negedge clk) begin
        chk("pkt_data", 32'(pkt_data), 32'(e_data));
        chk("pkt_valid", 32'(pkt_valid), 32'(e_valid));
        chk("bit_cnt", 32'(bit_cnt), mode == 2 ? 4 : bits.size());
        chk("busy", 32'(busy), 32'(mode != 0));
        chk("abort", 32'(abort), 32'(e_abort));
        if (pkt_valid && pkt_ready) xfers.push_back(pkt_data);
        if (abort) n_abort++;
        if (pkt_valid) n_valid++;
    end
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask
    task automatic set(input int b, input logic v);
        if (b == 0) start = v;
        else if (b == 1) key1 = v;
        else key2 = v;
    endtask
    task automatic press(input int b);
        set(b, 1);
        tick(D + 4);
        set(b, 0);
        tick(D + 4);
    endtask
    task automatic press_both();
        key1 = 1;
        key2 = 1;
        tick(D + 4);
        key1 = 0;
        key2 = 0;
        tick(D + 4);
    endtask
    initial begin
        tick(3);
        chk("rst_valid", 32'(pkt_valid), 0);
        chk("rst_cnt", 32'(bit_cnt), 0);
        chk("rst_busy", 32'(busy), 0);
        rst_n = 1;
        tick(2);
        pkt_ready = 1;
        nx = xfers.size();
        nv = n_valid;
        press(0); press(2); press(1); press(1); press(2);
        tick(4);
        chk("basic_xfers", xfers.size() - nx, 1);
        chk("basic_data", 32'(xfers[$]), 'b0110);
        chk("basic_vcycles", n_valid - nv, 1);
        press(0);
        for (int i = 0; i < 5; i++) begin
            key1 = 1; tick(2);
            key1 = 0; tick(2);
        end
        chk("bounce_none", 32'(bit_cnt), 0);
        key1 = 1;
        lat = 0;
        while (bit_cnt != 1 && lat < 20) begin
            tick(1);
            lat++;
        end
        chk("bounce_latency", lat, D + 3);
        tick(D + 4);
        key1 = 0;
        tick(D + 4);
        chk("bounce_one_bit", 32'(bit_cnt), 1);
        press(1); press(2); press(1);
        tick(3);
        chk("bounce_data", 32'(xfers[$]), 'b1101);
        pkt_ready = 0;
        nx = xfers.size();
        press(0);
        repeat (4) press(1);
        chk("bp_valid", 32'(pkt_valid), 1);
        chk("bp_data", 32'(pkt_data), 'b1111);
        repeat (2) press(2);
        chk("bp_hold_valid", 32'(pkt_valid), 1);
        chk("bp_hold_data", 32'(pkt_data), 'b1111);
        chk("bp_hold_cnt", 32'(bit_cnt), 4);
        chk("bp_no_xfer", xfers.size() - nx, 0);
        pkt_ready = 1;
        tick(3);
        chk("bp_xfer", xfers.size() - nx, 1);
        chk("bp_xfer_data", 32'(xfers[$]), 'b1111);
        chk("bp_valid_low", 32'(pkt_valid), 0);
        nx = xfers.size();
        press(0); press(1); press(1); press(0); press_both();
        press(2); press(2); press(2); press(1);
        tick(3);
        chk("restart_xfers", xfers.size() - nx, 1);
        chk("restart_data", 32'(xfers[$]), 'b0001);
        nx = xfers.size();
        na = n_abort;
        press(0); press(1);
        tick(T + 10);
        chk("to_abort", n_abort - na, 1);
        chk("to_busy", 32'(busy), 0);
        chk("to_cnt", 32'(bit_cnt), 0);
        press(1); press(2);
        tick(2);
        chk("to_idle_busy", 32'(busy), 0);
        chk("to_idle_cnt", 32'(bit_cnt), 0);
        chk("to_no_xfer", xfers.size() - nx, 0);
        chk("to_abort_once", n_abort - na, 1);
        press(0); press(1); press(2); press(1);
        chk("mid_cnt", 32'(bit_cnt), 3);
        rst_n = 0;
        tick(1);
        chk("mid_rst_cnt", 32'(bit_cnt), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_data", 32'(pkt_data), 0);
        rst_n = 1;
        nx = xfers.size();
        press(0); press(2); press(2); press(1); press(2);
        tick(3);
        chk("mid_after_data", 32'(xfers[$]), 'b0010);
        chk("mid_after_xfers", xfers.size() - nx, 1);
        pkt_ready = 0;
        press(0); press(1); press(2); press(1); press(2);
        chk("send_valid", 32'(pkt_valid), 1);
        chk("send_data", 32'(pkt_data), 'b1010);
        rst_n = 0;
        tick(1);
        chk("send_rst_valid", 32'(pkt_valid), 0);
        chk("send_rst_data", 32'(pkt_data), 0);
        chk("send_rst_busy", 32'(busy), 0);
        rst_n = 1;
        nx = xfers.size();
        pkt_ready = 1;
        tick(5);
        chk("send_rst_no_xfer", xfers.size() - nx, 0);
        for (int c = 0; c < 5000; c++) begin
            if ($urandom_range(0, 39) == 0) start = ~start;
            if ($urandom_range(0, 5) == 0) key1 = ~key1;
            if ($urandom_range(0, 5) == 0) key2 = ~key2;
            pkt_ready = $urandom_range(0, 3) != 0;
            rst_n = $urandom_range(0, 699) != 0;
            tick(1);
        end
        rst_n = 1;
        start = 0;
        key1 = 0;
        key2 = 0;
        tick(20);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/key_packet_assembler.md
Name: key_packet_assembler

Overview:
- Upstream entry stage for the four-buffer packet scheduler.
- Debounces the three push-button inputs: start, key1 (bit value 1) and key2 (bit value 0).
- After a start press, collects four bit-presses MSB-first into a 4-bit packet: {dest[1:0], payload[1:0]}.
- Presents the packet to the buffer/scheduler stage with a valid/ready handshake, so each completed entry is delivered exactly once.

Parameters:
- DEBOUNCE_CYCLES, 1000000, cycles an input must hold a new level before it is accepted (20 ms at 50 MHz); minimum 2.
- TIMEOUT_CYCLES, 500000000, maximum cycles allowed in COLLECT before the entry is aborted (10 s at 50 MHz); minimum 1.
- PKT_BITS, 4, bits per packet; fixed at 4 in this design.

Ports:
- clk  input  1  system clock, 50 MHz board clock.
- rst_n  input  1  reset: synchronous, active-low.
- start  input  1  raw start button, active-high, asynchronous to clk.
- key1  input  1  raw button entering a 1, active-high, asynchronous.
- key2  input  1  raw button entering a 0, active-high, asynchronous.
- pkt_data  output  4  assembled packet; [3:2] destination buffer, [1:0] payload.
- pkt_valid  output  1  packet available; held high until accepted.
- pkt_ready  input  1  downstream buffer can accept the packet.
- bit_cnt  output  3  bits collected so far (0..4), for LED display.
- busy  output  1  high in COLLECT or SEND.
- abort  output  1  one-cycle pulse when an entry times out.

Behaviour:
- Reset (rst_n low at a clk edge):
  - State goes to IDLE.
  - pkt_data=0, pkt_valid=0, bit_cnt=0, busy=0, abort=0.
  - Debounce counters, synchronisers and the timeout counter clear to 0; every debounced level clears to 0.
  - Reset applies in any state and discards any partial or unaccepted packet.
- Input conditioning, per button:
  - 2-FF synchroniser feeds the debouncer.
  - The debounced level changes only after the synchronised input has differed from it for DEBOUNCE_CYCLES consecutive cycles.
  - A press event is a one-cycle pulse on a 0->1 change of the debounced level.
  - Total latency from a raw clean edge to the press pulse is DEBOUNCE_CYCLES+2 cycles.
- FSM states: IDLE, COLLECT, SEND.
- IDLE:
  - busy=0.
  - A start press moves to COLLECT with bit_cnt=0 and the timeout counter at 0.
  - key1 and key2 presses are ignored.
- COLLECT:
  - busy=1.
  - A key1 press alone shifts 1 in: shreg <= {shreg[2:0],1}, bit_cnt+1.
  - A key2 press alone shifts 0 in the same way.
  - key1 and key2 presses in the same cycle: both ignored, no shift.
  - A start press restarts the entry: bit_cnt=0, shift register cleared, timeout counter cleared. It takes priority over a same-cycle bit press.
  - When bit_cnt reaches 4, the next cycle loads pkt_data, sets pkt_valid=1 and enters SEND. Latency is 1 cycle from the 4th press pulse to pkt_valid high.
  - The timeout counter increments every cycle in COLLECT and clears on each accepted bit press.
  - When the counter reaches TIMEOUT_CYCLES-1: abort pulses 1 cycle, bit_cnt=0, state goes to IDLE, and no packet is produced.
- SEND:
  - busy=1; pkt_valid=1; pkt_data is stable and bit_cnt=4.
  - Transfer occurs on a cycle with pkt_valid && pkt_ready. The next cycle gives pkt_valid=0, bit_cnt=0, state IDLE.
  - If pkt_ready is high on entry, pkt_valid is high for exactly 1 cycle.
  - All button presses, including start, are ignored in SEND.
  - Releasing pkt_ready while pkt_valid is high is legal; pkt_valid and pkt_data do not change until the transfer.
- pkt_data holds its last value after the transfer; consumers must qualify it with pkt_valid.
- Counter widths use $clog2 of the parameter; counters saturate, never wrap.

Decomposition:
- Shared package holds:
  - the FSM state enum (IDLE, COLLECT, SEND);
  - the PKT_BITS constant;
  - field-slice constants DEST_MSB=3, DEST_LSB=2, PAY_MSB=1, PAY_LSB=0, shared with the buffer/scheduler stage.
- One sub-module, key_debounce:
  - parameter DEBOUNCE_CYCLES;
  - ports clk, rst_n, raw, level, press;
  - instantiated three times.

Test Plan (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=50):
- Basic entry: start, then key2, key1, key1, key2 (clean presses, pkt_ready=1) -> pkt_data=4'b0110, pkt_valid high exactly 1 cycle, bit_cnt sequence 0,1,2,3,4,0.
- Bounce: key1 toggles every 2 cycles for 20 cycles, then holds high -> exactly one bit shifted in, DEBOUNCE_CYCLES+2 cycles after the stable level begins.
- Backpressure: enter 4'b1111 with pkt_ready=0 for 30 cycles, with key2 presses during the wait -> pkt_valid held, pkt_data=4'b1111 stable, no shift. Raising pkt_ready transfers once.
- Restart and simultaneous keys: start, key1, key1, start, key1+key2 in the same cycle, then key2, key2, key2, key1 -> pkt_data=4'b0001; the dual press adds no bit.
- Timeout: start, key1, then idle 50 cycles -> abort pulses once, busy=0, bit_cnt=0, no pkt_valid. Keys pressed in IDLE afterwards produce nothing.
- Reset mid-operation: rst_n low for 1 cycle after 3 bits, or while in SEND -> all outputs 0, state IDLE. A following start plus 4 presses yields a correct packet.
